// File: rtl/rr_share_arbiter.sv
// Round-robin arbiter for a shared resource. Each owner may hold the grant for
// at most MAX_HOLD cycles. Each requester has a saturating counter of its grants.
module rr_share_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int CW       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout,
  output logic [N*CW-1:0]      cnt_flat
);

  localparam int IW = $clog2(N);
  localparam int HW = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]    r_state;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_id;
  logic [IW-1:0] r_last;
  logic [HW-1:0] r_hold;
  logic          r_timeout;

  logic          w_found;
  logic [IW-1:0] w_win_idx;
  logic [N-1:0]  w_win_oh;
  logic          w_owner_req;
  logic          w_hold_max;
  logic          w_grant_evt;
  int            w_idx;

  // Search upward from the requester after the previous owner, wrapping at N-1.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_win_oh  = '0;
    w_idx     = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_last) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = IW'(w_idx);
      end
    end
    if (w_found) begin
      w_win_oh[w_win_idx] = 1'b1;
    end
  end

  assign w_owner_req = |(req & r_grant);
  assign w_hold_max  = (r_hold == HW'(MAX_HOLD));
  assign w_grant_evt = (r_state == S_IDLE) && w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_id      <= '0;
      r_last    <= IW'(N - 1);
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_OWN;
            r_grant <= w_win_oh;
            r_id    <= w_win_idx;
            r_last  <= w_win_idx;
            r_hold  <= HW'(1);
          end
        end
        S_OWN: begin
          // A release on the limit edge wins over the timeout.
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_hold  <= '0;
          end else if (w_hold_max) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_grant_evt && w_win_oh[g] && (r_cnt != {CW{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign cnt_flat[g*CW +: CW] = r_cnt;
  end

  assign grant    = r_grant;
  assign grant_id = r_id;
  assign busy     = (r_state == S_OWN);
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_rr_share_arbiter.sv
// Bench for rr_share_arbiter: a behavioural owner/hold model checked every
// negedge, plus hand-computed expectations for the directed scenarios.
module tb_rr_share_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int CW       = 8;
  localparam int IW       = $clog2(N);

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0]      grant;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              timeout;
  logic [N*CW-1:0]   cnt_flat;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  // Model state: owner index (-1 = free), hold length, last owner, counts.
  int mOwner   = -1;
  int mHold    = 0;
  int mLast    = N - 1;
  int mId      = 0;
  bit mTimeout = 0;
  int mCnt[N]  = '{default: 0};

  int g0Cycles = 0;
  int toCount  = 0;

  rr_share_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .grant_id(grant_id),
    .busy(busy), .timeout(timeout), .cnt_flat(cnt_flat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input int cycles);
    req = r;
    repeat (cycles) tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // The model decides ownership from the arbitration rules directly.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner = -1; mHold = 0; mLast = N - 1; mId = 0; mTimeout = 0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
    end else begin
      mTimeout = 0;
      if (mOwner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (mLast + k) % N;
          if (mOwner < 0 && req[c]) mOwner = c;
        end
        if (mOwner >= 0) begin
          mId = mOwner; mLast = mOwner; mHold = 1;
          if (mCnt[mOwner] < (1 << CW) - 1) mCnt[mOwner]++;
        end
      end else if (!req[mOwner]) begin
        mOwner = -1;
      end else if (mHold == MAX_HOLD) begin
        mOwner = -1; mTimeout = 1;
      end else begin
        mHold++;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      logic [N-1:0]    expGrant;
      logic [N*CW-1:0] expCnt;
      expGrant = '0;
      if (mOwner >= 0) expGrant[mOwner] = 1'b1;
      for (int i = 0; i < N; i++) expCnt[i*CW +: CW] = CW'(mCnt[i]);
      checkOutput("model_grant", 64'(grant), 64'(expGrant));
      checkOutput("model_grant_id", 64'(grant_id), 64'(mId));
      checkOutput("model_busy", 64'(busy), 64'(mOwner >= 0));
      checkOutput("model_timeout", 64'(timeout), 64'(mTimeout));
      checkOutput("model_cnt", 64'(cnt_flat), 64'(expCnt));
      if (grant == 4'b0001) g0Cycles++;
      if (timeout) toCount++;
    end
  end

  logic [N-1:0] rotSeq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] vecReq [6] = '{4'b1010, 4'b0000, 4'b0101, 4'b1000, 4'b0011, 4'b0000};
  int           vecLen [6] = '{3, 1, 6, 2, 7, 2};

  initial begin
    int g0Start;
    int toStart;
    rst_n = 1'b0;
    req   = '0;
    #3;
    checkOutput("reset_grant", 64'(grant), 64'h0);
    checkOutput("reset_grant_id", 64'(grant_id), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_timeout", 64'(timeout), 64'h0);
    checkOutput("reset_cnt", 64'(cnt_flat), 64'h0);
    tick();
    checkEn = 1;
    tick();
    rst_n = 1'b1;

    // Single requester held for two sampled edges.
    g0Start = g0Cycles;
    toStart = toCount;
    applyStimulus(4'b0001, 2);
    applyStimulus(4'b0000, 3);
    checkOutput("single_cnt0", 64'(cnt_flat[7:0]), 64'd1);
    checkOutput("single_grant_cycles", 64'(g0Cycles - g0Start), 64'd2);
    checkOutput("single_no_timeout", 64'(toCount - toStart), 64'd0);

    // Everyone requesting: four-cycle holds, one idle cycle with a timeout pulse.
    doReset();
    req = 4'b1111;
    @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checkOutput("rot_grant", 64'(grant), 64'((i % 5 == 4) ? 4'b0000 : rotSeq[i / 5]));
      checkOutput("rot_timeout", 64'(timeout), 64'(i % 5 == 4));
    end
    req = 4'b0000;
    tick();

    // Owner 1 drops on its fourth owned edge: release, then requester 2 wins.
    applyStimulus(4'b0110, 4);
    req = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    checkOutput("drop_grant", 64'(grant), 64'h0);
    checkOutput("drop_timeout", 64'(timeout), 64'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("next_grant", 64'(grant), 64'b0100);
    checkOutput("next_grant_id", 64'(grant_id), 64'd2);

    // Asynchronous reset in the middle of requester 2's ownership.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_grant", 64'(grant), 64'h0);
    checkOutput("async_busy", 64'(busy), 64'h0);
    checkOutput("async_cnt", 64'(cnt_flat), 64'h0);
    checkOutput("async_timeout", 64'(timeout), 64'h0);
    tick();
    tick();
    req   = 4'b1111;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_grant", 64'(grant), 64'b0001);
    checkOutput("post_reset_id", 64'(grant_id), 64'd0);
    tick();

    for (int v = 0; v < 6; v++) applyStimulus(vecReq[v], vecLen[v]);

    // Requester 0 granted 300 times with single-cycle holds.
    doReset();
    for (int n = 0; n < 300; n++) begin
      applyStimulus(4'b0001, 1);
      applyStimulus(4'b0000, 1);
    end
    checkOutput("sat_cnt", 64'(cnt_flat), 64'h0000_00FF);

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
